// File: rtl/bitstream_pkg.sv
// ============================================================================
// bitstream_pkg : shared FSM states, default link constants, period classifier
// Rev 1.0
// ============================================================================
`default_nettype none

package bitstream_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    MEAS = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_ONE  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_BAD  = 2'd2
  } bit_class_t;

  localparam int unsigned c_def_datalen  = 64;
  localparam int unsigned c_def_cntlen   = 8;
  localparam int unsigned c_def_clk_div1 = 16;
  localparam int unsigned c_def_clk_div2 = 32;
  localparam int unsigned c_def_tol      = 3;

  // Unsigned window test written as p+tol >= div && p <= div+tol to avoid underflow
  function automatic bit_class_t classify_period(input int unsigned p,
                                                 input int unsigned div1,
                                                 input int unsigned div2,
                                                 input int unsigned tol);
    bit_class_t cls;
    cls = CLS_BAD;
    if ((p + tol >= div1) && (p <= div1 + tol))
      cls = CLS_ONE;
    else if ((p + tol >= div2) && (p <= div2 + tol))
      cls = CLS_ZERO;
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync_edge.sv
// ============================================================================
// bit_sync_edge : 2-FF synchroniser plus registered copy for rising-edge detect
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync = r_sync;
  assign rise = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/bitstream_receiver.sv
// ============================================================================
// bitstream_receiver : recovers a DATALEN-bit word from a two-period bitstream
// Optional differential-pair check enabled by macro RX_DIFF_CHECK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module bitstream_receiver
  import bitstream_pkg::*;
#(
  parameter int unsigned DATALEN  = c_def_datalen,
  parameter int unsigned CNTLEN   = c_def_cntlen,
  parameter int unsigned CLK_DIV1 = c_def_clk_div1,
  parameter int unsigned CLK_DIV2 = c_def_clk_div2,
  parameter int unsigned TOL      = c_def_tol
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               inp,
  input  logic               inn,
  output logic [DATALEN-1:0] dataout,
  output logic               valid,
  output logic               busy,
  output logic               err,
  output logic [CNTLEN-1:0]  bitcnt
);

  localparam logic [CNTLEN-1:0] c_cnt_max    = '1;
  localparam int unsigned       c_arm_limit  = 4 * CLK_DIV2;
  localparam int unsigned       c_meas_limit = 2 * CLK_DIV2;

  state_t             r_state;
  state_t             w_next;
  logic [CNTLEN-1:0]  r_cnt;
  logic [CNTLEN-1:0]  r_bitcnt;
  logic [DATALEN-1:0] r_shift;
  logic [DATALEN-1:0] r_data;
  logic               r_err;
  logic               w_sync_p;
  logic               w_rise_p;
  logic               w_diff_bad;
  logic               w_word_full;
  logic               w_arm_tmo;
  logic               w_meas_tmo;
  logic               w_accept;
  logic               w_arm_req;
  bit_class_t         w_class;

  bit_sync_edge u_sync_p (
    .clk  (clk),
    .rst  (rst),
    .din  (inp),
    .sync (w_sync_p),
    .rise (w_rise_p)
  );

`ifdef RX_DIFF_CHECK_EN
  logic       w_sync_n;
  logic       w_rise_n_unused;
  logic [1:0] r_same;

  bit_sync_edge u_sync_n (
    .clk  (clk),
    .rst  (rst),
    .din  (inn),
    .sync (w_sync_n),
    .rise (w_rise_n_unused)
  );

  // Third consecutive cycle of equal legs while busy marks a broken pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_same <= 2'd0;
    else if (busy && (w_sync_p == w_sync_n)) begin
      if (r_same != 2'd3)
        r_same <= r_same + 2'd1;
    end else
      r_same <= 2'd0;
  end

  assign w_diff_bad = busy && (w_sync_p == w_sync_n) && (r_same >= 2'd2);
`else
  logic w_unused;
  assign w_unused   = ^{inn, w_sync_p};
  assign w_diff_bad = 1'b0;
`endif

  assign w_class     = classify_period(32'(r_cnt), CLK_DIV1, CLK_DIV2, TOL);
  assign w_word_full = (r_bitcnt == CNTLEN'(DATALEN));
  assign w_arm_tmo   = (32'(r_cnt) >= c_arm_limit) || (r_cnt == c_cnt_max);
  assign w_meas_tmo  = (32'(r_cnt) >= c_meas_limit);
  assign w_arm_req   = (r_state == IDLE) && start;
  assign w_accept    = (r_state == MEAS) && !w_word_full && !w_diff_bad &&
                       w_rise_p && (w_class != CLS_BAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = ARM;
      ARM: begin
        if (w_diff_bad)      w_next = ERR;
        else if (w_rise_p)   w_next = MEAS;
        else if (w_arm_tmo)  w_next = ERR;
      end
      MEAS: begin
        if (w_word_full)     w_next = DONE;
        else if (w_diff_bad) w_next = ERR;
        else if (w_rise_p) begin
          if (w_class == CLS_BAD) w_next = ERR;
        end else if (w_meas_tmo) w_next = ERR;
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_rise_p || w_arm_req)
        r_cnt <= CNTLEN'(1);
      else if (r_cnt != c_cnt_max)
        r_cnt <= r_cnt + CNTLEN'(1);

      if (w_arm_req) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
        r_err    <= 1'b0;
      end else if (w_accept) begin
        r_bitcnt <= r_bitcnt + CNTLEN'(1);
        r_shift  <= {r_shift[DATALEN-2:0], (w_class == CLS_ONE)};
      end

      if ((r_state == MEAS) && w_word_full)
        r_data <= r_shift;

      if (w_next == ERR)
        r_err <= 1'b1;
    end
  end

  assign dataout = r_data;
  assign valid   = (r_state == DONE);
  assign busy    = (r_state == ARM) || (r_state == MEAS);
  assign err     = r_err;
  assign bitcnt  = r_bitcnt;

endmodule

`default_nettype wire

// File: tb/tb_bitstream_receiver.sv
// ============================================================================
// tb_bitstream_receiver : directed self-checking bench for bitstream_receiver
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bitstream_receiver;

  localparam int DLEN = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            inp;
  logic            inn;
  logic [DLEN-1:0] dataout;
  logic            valid;
  logic            busy;
  logic            err;
  logic [7:0]      bitcnt;

  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              vcount = 0;
  int              vcyc = 0;
  int              close_cyc = 0;
  logic [DLEN-1:0] vdata = '0;
  logic            vbusy = 1'b1;
  bit              tie = 1'b0;

  bitstream_receiver #(
    .DATALEN  (DLEN),
    .CNTLEN   (8),
    .CLK_DIV1 (16),
    .CLK_DIV2 (32),
    .TOL      (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .inp     (inp),
    .inn     (inn),
    .dataout (dataout),
    .valid   (valid),
    .busy    (busy),
    .err     (err),
    .bitcnt  (bitcnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount <= vcount + 1;
      vdata  <= dataout;
      vbusy  <= busy;
      vcyc   <= cyc;
    end
  end

  task automatic wait_clk(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    inp = v;
    inn = tie ? v : ~v;
  endtask

  task automatic send_bit(input logic b, input int n);
    drive(1'b1);
    wait_clk(n / 2);
    drive(1'b0);
    wait_clk(n - n / 2);
  endtask

  task automatic send_word(input logic [DLEN-1:0] d, input int from, input int to);
    for (int i = from; i >= to; i--)
      send_bit(d[i], d[i] ? 16 : 32);
  endtask

  task automatic close_word();
    drive(1'b1);
    close_cyc = cyc;
    wait_clk(8);
    drive(1'b0);
    wait_clk(8);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_clk(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0;
    rst   = 1'b0;
    drive(1'b0);
    #23 rst = 1'b1;
    #1;
    total++; if (dataout !== '0) begin bad++; $display("FAIL reset_dataout: got %h want 0", dataout); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (bitcnt !== 8'd0) begin bad++; $display("FAIL reset_bitcnt: got %0d want 0", bitcnt); end
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, valid); end
  endtask

  task automatic test_loopback();
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL loop_busy_arm: got %b want 1", busy); end
    send_word(16'hA5C3, 15, 0);
    close_word();
    total++; if (vcount !== 1) begin bad++; $display("FAIL loop_vcount: got %0d want 1", vcount); end
    total++; if (vdata !== 16'hA5C3) begin bad++; $display("FAIL loop_vdata: got %h want a5c3", vdata); end
    total++; if (dataout !== 16'hA5C3) begin bad++; $display("FAIL loop_dataout: got %h want a5c3", dataout); end
    total++; if (bitcnt !== 8'd16) begin bad++; $display("FAIL loop_bitcnt: got %0d want 16", bitcnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL loop_err: got %b want 0", err); end
    total++; if (vbusy !== 1'b0) begin bad++; $display("FAIL loop_busy_at_valid: got %b want 0", vbusy); end
    total++; if (vcyc - close_cyc !== 4) begin bad++; $display("FAIL loop_latency: got %0d want 4", vcyc - close_cyc); end
  endtask

  task automatic test_tolerance();
    logic [DLEN-1:0] d;
    d = 16'h3C96;
    pulse_start();
    for (int i = 15; i >= 0; i--)
      send_bit(d[i], d[i] ? ((i % 2 == 1) ? 13 : 19) : ((i % 2 == 1) ? 35 : 29));
    close_word();
    total++; if (vcount !== 2) begin bad++; $display("FAIL tol_vcount: got %0d want 2", vcount); end
    total++; if (dataout !== 16'h3C96) begin bad++; $display("FAIL tol_dataout: got %h want 3c96", dataout); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tol_err: got %b want 0", err); end
  endtask

  task automatic test_bad_period();
    pulse_start();
    send_bit(1'b1, 16);
    send_bit(1'b0, 32);
    send_bit(1'b1, 24);
    close_word();
    wait_clk(5);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err: got %b want 1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_busy: got %b want 0", busy); end
    total++; if (vcount !== 2) begin bad++; $display("FAIL bad_vcount: got %0d want 2", vcount); end
    total++; if (dataout !== 16'h3C96) begin bad++; $display("FAIL bad_dataout: got %h want 3c96", dataout); end
    total++; if (bitcnt !== 8'd2) begin bad++; $display("FAIL bad_bitcnt: got %0d want 2", bitcnt); end
  endtask

  task automatic test_timeout();
    pulse_start();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_cleared: got %b want 0", err); end
    send_word(16'hB000, 15, 11);
    drive(1'b1);
    wait_clk(8);
    drive(1'b0);
    wait_clk(40);
    total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_early: got err=%b busy=%b want 0 1", err, busy); end
    total++; if (bitcnt !== 8'd5) begin bad++; $display("FAIL tmo_bitcnt: got %0d want 5", bitcnt); end
    wait_clk(32);
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL tmo_late: got err=%b busy=%b want 1 0", err, busy); end
    total++; if (dataout !== 16'h3C96) begin bad++; $display("FAIL tmo_dataout: got %h want 3c96", dataout); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_word(16'h5A0F, 15, 8);
    drive(1'b1);
    wait_clk(6);
    total++; if (bitcnt !== 8'd8) begin bad++; $display("FAIL rmid_bitcnt_pre: got %0d want 8", bitcnt); end
    #2 rst = 1'b1;
    #1;
    total++; if (bitcnt !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_abort: got bitcnt=%0d busy=%b want 0 0", bitcnt, busy); end
    total++; if (dataout !== '0 || valid !== 1'b0) begin bad++; $display("FAIL rmid_outputs: got dataout=%h valid=%b want 0 0", dataout, valid); end
    wait_clk(2);
    rst = 1'b0;
    drive(1'b0);
    wait_clk(4);
    pulse_start();
    send_word(16'h5A0F, 15, 0);
    close_word();
    total++; if (dataout !== 16'h5A0F) begin bad++; $display("FAIL rmid_dataout: got %h want 5a0f", dataout); end
    total++; if (vcount !== 3) begin bad++; $display("FAIL rmid_vcount: got %0d want 3", vcount); end
  endtask

  task automatic test_arm_timeout();
    pulse_start();
    wait_clk(100);
    total++; if (busy !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL arm_wait: got busy=%b err=%b want 1 0", busy, err); end
    wait_clk(40);
    total++; if (busy !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL arm_tmo: got busy=%b err=%b want 0 1", busy, err); end
  endtask

  task automatic test_start_while_busy();
    pulse_start();
    send_word(16'hBEEF, 15, 10);
    drive(1'b1);
    wait_clk(3);
    start = 1'b1;
    wait_clk(1);
    start = 1'b0;
    wait_clk(4);
    drive(1'b0);
    wait_clk(8);
    send_word(16'hBEEF, 8, 0);
    close_word();
    total++; if (dataout !== 16'hBEEF) begin bad++; $display("FAIL swb_dataout: got %h want beef", dataout); end
    total++; if (vcount !== 4 || err !== 1'b0) begin bad++; $display("FAIL swb_status: got vcount=%0d err=%b want 4 0", vcount, err); end
  endtask

  task automatic test_diff();
    pulse_start();
    send_word(16'hC3A5, 15, 12);
    tie = 1'b1;
    send_word(16'hC3A5, 11, 0);
    close_word();
    tie = 1'b0;
    drive(1'b0);
    wait_clk(4);
`ifdef RX_DIFF_CHECK_EN
    total++; if (err !== 1'b1) begin bad++; $display("FAIL diff_err: got %b want 1", err); end
    total++; if (vcount !== 4 || dataout !== 16'hBEEF) begin bad++; $display("FAIL diff_hold: got vcount=%0d dataout=%h want 4 beef", vcount, dataout); end
`else
    total++; if (err !== 1'b0) begin bad++; $display("FAIL diff_err: got %b want 0", err); end
    total++; if (vcount !== 5 || dataout !== 16'hC3A5) begin bad++; $display("FAIL diff_rx: got vcount=%0d dataout=%h want 5 c3a5", vcount, dataout); end
`endif
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_tolerance();
    test_bad_period();
    test_timeout();
    test_reset_mid();
    test_arm_timeout();
    test_start_while_busy();
    test_diff();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bitstream_receiver.md
Name: bitstream_receiver

Overview:
- Receive-side counterpart of the bitstreamer: recovers a DATALEN-bit word from a two-frequency differential bitstream.
- Symbol encoding: one full input period (rising edge to rising edge) carries one bit. A period of CLK_DIV1 clocks is '1'; a period of CLK_DIV2 clocks is '0'. Bits arrive MSB first.
- Used for loopback and antenna-modulation link testing. Output is a parallel word with a valid pulse and an error flag.

Parameters:
- DATALEN, 64: number of bits per received word.
- CNTLEN, 8: width of the period counter; must satisfy 2^CNTLEN > 2*CLK_DIV2.
- CLK_DIV1, 16: nominal period in clocks of a '1' symbol.
- CLK_DIV2, 32: nominal period in clocks of a '0' symbol; must be greater than CLK_DIV1.
- TOL, 3: allowed +/- period deviation in clocks.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset.
- start, input, 1: arm the receiver (one-cycle pulse).
- inp, input, 1: positive bitstream line, asynchronous.
- inn, input, 1: negative bitstream line, asynchronous.
- dataout, output, DATALEN: recovered word.
- valid, output, 1: one-cycle pulse when dataout is updated.
- busy, output, 1: high from arm until DONE or ERR.
- err, output, 1: sticky error flag, cleared by start or rst.
- bitcnt, output, CNTLEN: number of bits received so far.

Behaviour:
- Reset is asynchronous and active-high on rst; there is one clock, clk. Reset values: dataout=0, valid=0, busy=0, err=0, bitcnt=0, state=IDLE, synchronisers=0.
- inp passes through a 2-FF synchroniser followed by a registered copy. A rising edge is detected when sync=1 and prev=0, so edges are seen 3 clocks after the pin changes.
- Period counter is CNTLEN wide, saturates at all-ones, and resets to 1 on each detected edge.
- State IDLE:
  - start -> ARM: busy=1, err=0, bitcnt=0, shift register cleared.
- State ARM: waits for the first rising edge.
  - Edge -> MEAS, counter restarted.
  - No edge within 4*CLK_DIV2 clocks -> ERR.
- State MEAS: on each rising edge, classify the count P.
  - |P-CLK_DIV1| <= TOL: shift in '1'.
  - |P-CLK_DIV2| <= TOL: shift in '0'.
  - Otherwise -> ERR.
  - Each accepted bit increments bitcnt.
  - Counter reaching 2*CLK_DIV2 with no edge -> ERR (timeout).
- Word completion: when bitcnt reaches DATALEN, the next cycle loads dataout from the shift register, pulses valid for 1 cycle, and goes to DONE.
  - Latency: valid occurs 4 clocks after the pin edge that ends the last bit.
- State DONE: busy=0; returns to IDLE the next cycle. dataout holds until the next completed word.
- State ERR: err=1, busy=0, valid never pulses, dataout unchanged; returns to IDLE the next cycle. err stays set until start.
- start while busy: ignored; the reception in progress continues.
- start in the same cycle as DONE/ERR exit: ignored; the user must re-pulse start in IDLE.
- rst mid-word: immediate abort to reset values; no valid pulse.
- Arithmetic: all comparisons are unsigned on the counter. Use the saturated count for classification.

Optional Feature:
- Macro RX_DIFF_CHECK_EN.
- When defined: inn is synchronised identically to inp. If the synchronised inp equals inn for more than 2 consecutive clocks while busy, go to ERR (broken differential pair).
- When undefined: inn is unused (tie-off lint waiver), and behaviour is exactly as described above.

Decomposition:
- Shared package bitstream_pkg holds:
  - the state enum (IDLE, ARM, MEAS, DONE, ERR), also used by the bitstreamer's FSM naming;
  - default DATALEN/CNTLEN/CLK_DIV1/CLK_DIV2 constants;
  - a function classifying a period into ONE/ZERO/BAD given TOL.
- One sub-module, bit_sync_edge: 2-FF synchroniser plus rising-edge detector, instantiated once, or twice with RX_DIFF_CHECK_EN.

Test Plan:
- Reset defaults: assert rst mid-clock with no start -> all outputs 0 immediately; state stays IDLE.
- Loopback: DATALEN=16, bitstreamer transmits 16'hA5C3 -> valid pulses once, dataout=16'hA5C3, bitcnt=16, err=0, busy deasserts the same cycle valid pulses.
- Tolerance: drive periods of 13 and 35 clocks (in range) -> bits accepted. A period of 24 clocks -> err=1, no valid pulse, busy=0.
- Timeout: after 5 good bits, hold inp low for 70 clocks -> err=1 at count 64; dataout keeps its previous value.
- Reset mid-word: after 8 bits, pulse rst -> bitcnt=0, busy=0. A following start plus a full 64-bit word -> correct dataout.
- With RX_DIFF_CHECK_EN: tie inn=inp mid-word -> err=1 within 3 clocks after sync. Without the macro, the same stimulus -> normal reception.
